shift_symbol_serializer: RTL and testbench
==========================================

SHIFT_SYMBOL_SERIALIZER -- requirements
Module: shift_symbol_serializer

Interface
REQ-001 The block SHALL have parameter SYM_W, default 5, meaning the width of one symbol in bits.
REQ-002 The block SHALL have parameter NSYM, default 10, meaning the number of symbols per word; the word width is SYM_W*NSYM (50).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  upstream word present.
REQ-005 The block SHALL have port in_data  input  SYM_W*NSYM  shifted word from the right-shift stage.
REQ-006 The block SHALL have port in_word_ok  input  1  the shift stage's out_valid (shift amount legal).
REQ-007 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port out_valid  output  1  out_sym holds a valid symbol.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the symbol.
REQ-010 The block SHALL have port out_sym  output  SYM_W  current symbol, least-significant symbol first.
REQ-011 The block SHALL have port out_idx  output  clog2(NSYM)  index of the current symbol, 0..NSYM-1.
REQ-012 The block SHALL have port out_last  output  1  asserted with symbol NSYM-1.
REQ-013 The block SHALL have port drop_count  output  8  saturating count of dropped illegal words.

Function
REQ-014 The input handshake SHALL complete on a cycle with in_valid=1 and in_ready=1; the output handshake SHALL complete on a cycle with out_valid=1 and out_ready=1.
REQ-015 The FSM SHALL have exactly two states: IDLE (no word held) and SEND (word held, symbols pending).
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 An accepted word with in_word_ok=1 SHALL be captured into a SYM_W*NSYM holding register, the index SHALL be set to 0, and the FSM SHALL move to SEND on the next cycle.
REQ-018 An accepted word with in_word_ok=0 SHALL be discarded, the FSM SHALL remain in IDLE, and drop_count SHALL increment by 1, saturating at 255.
REQ-019 In SEND, out_valid SHALL be 1, out_sym SHALL equal holding[idx*SYM_W +: SYM_W], and out_last SHALL equal (idx==NSYM-1).
REQ-020 In SEND, out_sym, out_idx and out_last SHALL hold stable while out_ready=0.
REQ-021 In SEND with idx<NSYM-1, each output handshake SHALL increment idx by 1.
REQ-022 In SEND, in_ready SHALL be 1 only when idx==NSYM-1 and out_ready=1 (combinational from out_ready), and SHALL be 0 otherwise.
REQ-023 On an output handshake with idx==NSYM-1:
- an input handshake in the same cycle with in_word_ok=1 SHALL load the new word, set idx to 0 and stay in SEND (back-to-back, no bubble);
- with in_word_ok=0 it SHALL increment drop_count and go to IDLE;
- with no input handshake it SHALL go to IDLE.
REQ-024 Latency from an accepted legal word to its symbol 0 on out_sym SHALL be 1 cycle; a legal word SHALL occupy exactly NSYM output handshakes.
REQ-025 in_data SHALL be captured verbatim, with no reordering of fill symbols or any other symbols.

Reset
REQ-026 Asserting rst SHALL, asynchronously, set the state to IDLE, the holding register to 0, idx to 0 and drop_count to 0.
REQ-027 During and immediately after reset, outputs SHALL be out_valid=0, out_sym=0, out_idx=0, out_last=0, in_ready=1 and drop_count=0.
REQ-028 Reset asserted in SEND SHALL abandon the partial word; no remaining symbol of that word SHALL be emitted after reset.

Structure
REQ-029 Package shift_pkg SHALL hold SYM_W, NSYM, WORD_W=SYM_W*NSYM, IDX_W=clog2(NSYM) and the state enum {IDLE, SEND}; the right-shift stage and this block SHALL share these.
REQ-030 The block SHALL be a single module; the 8-bit saturating counter MAY be sub-module sat_counter (parameter WIDTH).

Verification
REQ-031 The bench SHALL cover: in_data=0x3_FFFF_FFFF_FFE1 (sym0=1, syms1..9=31), in_word_ok=1, out_ready=1 -> one cycle later, 10 consecutive symbols 1,31,...,31; out_last on idx 9; then IDLE.
REQ-032 The bench SHALL cover: out_ready toggled 1,0,0,1 during SEND -> out_sym and out_idx stable on the 0-cycles; all 10 symbols delivered exactly once.
REQ-033 The bench SHALL cover: two legal words, the second held valid from the last symbol of the first -> symbol 0 of word 2 on the cycle after word 1's last handshake, no idle cycle.
REQ-034 The bench SHALL cover: 3 words with in_word_ok=0 in IDLE -> no out_valid, drop_count=3; 300 such words -> drop_count=255.
REQ-035 The bench SHALL cover: rst pulsed after symbol 4 of a word -> out_valid=0 at once, drop_count=0; symbols 5..9 never appear.
REQ-036 The bench SHALL cover: random in_valid/out_ready over 10k cycles against a scoreboard model -> symbol stream equals all legal words split LSB-first.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared parameters and state encoding for the right-shift stage and its symbol serializer.
package shift_pkg;

    localparam int unsigned SYM_W  = 5;
    localparam int unsigned NSYM   = 10;
    localparam int unsigned WORD_W = SYM_W * NSYM;
    localparam int unsigned IDX_W  = (NSYM > 1) ? $clog2(NSYM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/shift_symbol_serializer.sv
// Holds one shifted word and emits it symbol by symbol, LSB symbol first; illegal words are
// counted and dropped.
module shift_symbol_serializer
    import shift_pkg::*;
#(
    parameter int unsigned SYM_W = shift_pkg::SYM_W,
    parameter int unsigned NSYM  = shift_pkg::NSYM
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic [SYM_W*NSYM-1:0]                        in_data,
    input  logic                                         in_word_ok,
    output logic                                         in_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [SYM_W-1:0]                             out_sym,
    output logic [((NSYM > 1) ? $clog2(NSYM) : 1)-1:0]   out_idx,
    output logic                                         out_last,
    output logic [7:0]                                   drop_count
);

    localparam int unsigned IDX_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int unsigned DROP_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    state_t                         state_q, state_d;
    logic [NSYM-1:0][SYM_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           at_last;
    logic                           in_hs;
    logic                           out_hs;
    logic                           drop_inc;

    // A new word may enter only when the held one is fully gone after this cycle.
    assign at_last   = (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE) || (at_last && out_ready);
    assign out_valid = (state_q == SEND);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    assign out_sym  = out_valid ? hold_q[idx_q] : '0;
    assign out_idx  = idx_q;
    assign out_last = out_valid && at_last;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        drop_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    if (in_word_ok) begin
                        hold_d  = in_data;
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        // Back-to-back reload keeps SEND with no bubble.
                        if (in_hs && in_word_ok) begin
                            hold_d = in_data;
                        end else begin
                            state_d  = IDLE;
                            drop_inc = in_hs;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

endmodule

// File: tb/tb_shift_symbol_serializer.sv
// Bench for shift_symbol_serializer: a symbol-queue model checked every cycle plus directed
// literal expectations.
module tb_shift_symbol_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [49:0] in_data;
    logic        in_word_ok;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_sym;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [7:0]  drop_count;

    shift_symbol_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_word_ok (in_word_ok),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym    (out_sym),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sym;
        int         idx;
    } exp_sym_t;

    exp_sym_t exp_q[$];
    int       drop_exp    = 0;
    int       legal_words = 0;
    int       dut_syms    = 0;
    int       n_cmp       = 0;
    int       n_err       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the pending symbols of the held word; a word is legal-accepted only when the queue
    // is empty or about to empty.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst) begin
            exp_q.delete();
            drop_exp = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_sym", out_sym, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_drop_count", drop_count, 0);
        end else begin
            exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready);
            chk("m_out_valid", out_valid, exp_q.size() != 0);
            chk("m_in_ready", in_ready, exp_ready);
            chk("m_drop_count", drop_count, drop_exp);
            if (exp_q.size() != 0) begin
                chk("m_out_sym", out_sym, exp_q[0].sym);
                chk("m_out_idx", out_idx, exp_q[0].idx);
                chk("m_out_last", out_last, exp_q[0].idx == 9);
            end
            if (out_valid && out_ready) dut_syms++;
            if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_ready) begin
                if (in_word_ok) begin
                    for (int k = 0; k < 10; k++) exp_q.push_back('{in_data[k*5 +: 5], k});
                    legal_words++;
                end else if (drop_exp < 255) begin
                    drop_exp++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive_word(input logic [49:0] d, input logic ok, output int waited);
        bit done;
        done       = 1'b0;
        waited     = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_word_ok = ok;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
            if (in_ready) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int          wt;
        int          ndel;
        int          pat[4];
        logic [49:0] w;
        logic        prev_valid, prev_ready;
        logic [4:0]  prev_sym;
        logic [3:0]  prev_idx;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_word_ok = 1'b0; out_ready = 1'b0;
        @(negedge clk); #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_drop", drop_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // One legal word at full rate: 1 then nine 31s.
        out_ready = 1'b1;
        drive_word(50'h3_FFFF_FFFF_FFE1, 1'b1, wt);
        chk("t1_accept_wait", wt, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            chk("t1_valid", out_valid, 1);
            chk("t1_sym", out_sym, (k == 0) ? 1 : 31);
            chk("t1_idx", out_idx, k);
            chk("t1_last", out_last, k == 9);
        end
        @(negedge clk); #1;
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_ready", in_ready, 1);
        @(posedge clk); #1;

        // Backpressure 1,0,0,1: symbols hold still and each is delivered once.
        for (int k = 0; k < 10; k++) w[k*5 +: 5] = 5'(k + 3);
        out_ready = 1'b0;
        drive_word(w, 1'b1, wt);
        pat = '{1, 0, 0, 1};
        ndel = 0; prev_valid = 1'b0; prev_ready = 1'b1; prev_sym = '0; prev_idx = '0;
        for (int c = 0; c < 80 && ndel < 10; c++) begin
            out_ready = pat[c % 4][0];
            @(negedge clk); #1;
            if (out_valid && prev_valid && !prev_ready) begin
                chk("t2_stable_sym", out_sym, prev_sym);
                chk("t2_stable_idx", out_idx, prev_idx);
            end
            if (out_valid && out_ready) begin
                chk("t2_idx", out_idx, ndel);
                chk("t2_sym", out_sym, ndel + 3);
                ndel++;
            end
            prev_valid = out_valid; prev_ready = out_ready; prev_sym = out_sym; prev_idx = out_idx;
            @(posedge clk); #1;
        end
        chk("t2_count", ndel, 10);
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("t2_idle", out_valid, 0);
        @(posedge clk); #1;

        // Back-to-back: second word waits, enters on the first word's last symbol.
        drive_word(50'h1_2345_6789_ABCD, 1'b1, wt);
        drive_word(50'h2_FEDC_BA98_7654, 1'b1, wt);
        chk("t3_accept_wait", wt, 10);
        @(negedge clk); #1;
        chk("t3_b_valid", out_valid, 1);
        chk("t3_b_idx", out_idx, 0);
        chk("t3_b_sym", out_sym, 20);
        for (int c = 0; c < 20 && out_valid; c++) begin
            @(negedge clk); #1;
        end
        chk("t3_drained", out_valid, 0);
        @(posedge clk); #1;

        // Illegal words: counted, never emitted, saturating at 255.
        for (int i = 0; i < 3; i++) drive_word(50'h15, 1'b0, wt);
        @(negedge clk); #1;
        chk("t4_drop3", drop_count, 3);
        chk("t4_no_valid", out_valid, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 297; i++) drive_word(50'h2A, 1'b0, wt);
        @(negedge clk); #1;
        chk("t4_drop255", drop_count, 255);
        @(posedge clk); #1;

        // Reset after symbol 4 abandons the word.
        for (int k = 0; k < 10; k++) w[k*5 +: 5] = 5'(k + 20);
        drive_word(w, 1'b1, wt);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("t5_sym", out_sym, k + 20);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_drop", drop_count, 0);
        chk("t5_rst_idx", out_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            chk("t5_no_more", out_valid, 0);
        end
        @(posedge clk); #1;

        // Random traffic against the model.
        legal_words = 0;
        dut_syms    = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_word_ok = ($urandom_range(0, 19) < 17);
            in_data    = 50'({$urandom, $urandom});
            out_ready  = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        chk("t6_sym_count", dut_syms, legal_words * 10);
        chk("t6_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
